// File: rtl/svo_stream_timing_if.sv
// AXI-style pixel stream between the pixel generator and the raster timing block.
// tuser marks the first pixel of a frame.
interface svo_stream_timing_if #(
    parameter int BPP = 24
) ();
    logic           tvalid;
    logic           tready;
    logic [BPP-1:0] tdata;
    logic           tuser;

    modport master (output tvalid, output tdata, output tuser, input tready);
    modport slave  (input tvalid, input tdata, input tuser, output tready);
endinterface

// File: rtl/svo_stream_timing.sv
// Turns an AXI-style pixel stream into a timed raster (hsync/vsync/de/rgb).
// Free-running H/V counters, a small pixel FIFO and a frame-lock FSM that re-locks on errors.
module svo_stream_timing #(
    parameter int BPP        = 24,
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit HSYNC_POL  = 1'b0,
    parameter bit VSYNC_POL  = 1'b0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    svo_stream_timing_if.slave   in_axis,
    output logic                 out_hsync,
    output logic                 out_vsync,
    output logic                 out_de,
    output logic [BPP-1:0]       out_rgb,
    output logic                 locked,
    output logic                 underflow,
    output logic                 resync_err
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);
    localparam int AW      = $clog2(FIFO_DEPTH);

    localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [AW:0]   FIFO_FULL  = (AW + 1)'(FIFO_DEPTH);

    localparam logic [1:0] ST_SYNC  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic [1:0]    state;
    logic [1:0]    next_state;

    logic [BPP:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [BPP:0]  head;

    logic active;
    logic origin;
    logic hs;
    logic vs;
    logic full;
    logic empty;
    logic consume;
    logic starve;
    logic misalign;
    logic pop;
    logic flush;
    logic ready;
    logic fire;
    logic push;

    assign in_axis.tready = ready;

    // A pixel is due at every active position in RUN, and at the origin while ARMED.
    always_comb begin
        active     = (hcnt < H_ACT_END) && (vcnt < V_ACT_END);
        origin     = (hcnt == '0) && (vcnt == '0);
        hs         = (hcnt >= H_SYNC_BEG) && (hcnt < H_SYNC_END);
        vs         = (vcnt >= V_SYNC_BEG) && (vcnt < V_SYNC_END);
        full       = (count == FIFO_FULL);
        empty      = (count == '0);
        head       = mem[rd_ptr];
        consume    = ((state == ST_RUN) && active) || ((state == ST_ARMED) && origin);
        starve     = consume && empty;
        misalign   = consume && !empty && (head[BPP] != origin);
        pop        = consume && !empty && !misalign;
        flush      = starve || misalign;
        ready      = (state == ST_SYNC) ? 1'b1 : (!full || pop);
        fire       = in_axis.tvalid && ready;
        push       = fire && !flush && ((state != ST_SYNC) || in_axis.tuser);
        next_state = state;
        if (flush) begin
            next_state = ST_SYNC;
        end else if ((state == ST_SYNC) && fire && in_axis.tuser) begin
            next_state = ST_ARMED;
        end else if ((state == ST_ARMED) && pop) begin
            next_state = ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (hcnt == H_LAST) begin
            hcnt <= '0;
            vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
        end else begin
            hcnt <= hcnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_axis.tuser, in_axis.tdata};
        end
    end

    // A flush drops everything, including a beat accepted in the same cycle.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_SYNC;
            out_de     <= 1'b0;
            out_rgb    <= '0;
            out_hsync  <= ~HSYNC_POL;
            out_vsync  <= ~VSYNC_POL;
            locked     <= 1'b0;
            underflow  <= 1'b0;
            resync_err <= 1'b0;
        end else begin
            state      <= next_state;
            out_de     <= active;
            out_rgb    <= pop ? head[BPP-1:0] : '0;
            out_hsync  <= hs ? HSYNC_POL : ~HSYNC_POL;
            out_vsync  <= vs ? VSYNC_POL : ~VSYNC_POL;
            locked     <= (next_state == ST_RUN);
            underflow  <= starve;
            resync_err <= misalign;
        end
    end

endmodule
